key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 147 ++++++++++++++
 tb/tb_key_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Two-key pushbutton conditioner: per-key synchronizer and debounce FSM, a one-cycle
// step pulse on KEY[0] press, a debounced load level from KEY[1], and a press counter.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic [1:0] KEY,
  output logic       step_o,
  output logic       load_n_o,
  output logic [9:0] press_cnt_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_HI = 2'd0,
    COUNT_LO  = 2'd1,
    STABLE_LO = 2'd2,
    COUNT_HI  = 2'd3
  } key_state_t;

  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  key_state_t       state_r [2];
  key_state_t       state_s [2];
  logic [CNT_W-1:0] cnt_r   [2];
  logic [CNT_W-1:0] cnt_s   [2];
  logic [1:0]       lvl_r;
  logic [1:0]       lvl_s;
  logic [1:0]       fall_s;
  logic             step_r;
  logic [9:0]       press_cnt_r;

  // Two-flop synchronizers for the raw asynchronous keys
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= KEY;
      sync2_r <= sync1_r;
    end
  end

  // Next-state, counter and debounced-level decode for both key FSMs
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_s[k] = state_r[k];
      cnt_s[k]   = cnt_r[k];
      lvl_s[k]   = lvl_r[k];
      case (state_r[k])
        STABLE_HI: begin
          if (!sync2_r[k]) begin
            state_s[k] = COUNT_LO;
            cnt_s[k]   = '0;
          end else begin
            state_s[k] = STABLE_HI;
          end
        end
        COUNT_LO: begin
          if (sync2_r[k]) begin
            state_s[k] = STABLE_HI;
            cnt_s[k]   = '0;
          end else if (cnt_r[k] == CNT_LAST) begin
            state_s[k] = STABLE_LO;
            cnt_s[k]   = '0;
            lvl_s[k]   = 1'b0;
          end else begin
            cnt_s[k] = cnt_r[k] + CNT_W'(1);
          end
        end
        STABLE_LO: begin
          if (sync2_r[k]) begin
            state_s[k] = COUNT_HI;
            cnt_s[k]   = '0;
          end else begin
            state_s[k] = STABLE_LO;
          end
        end
        COUNT_HI: begin
          if (!sync2_r[k]) begin
            state_s[k] = STABLE_LO;
            cnt_s[k]   = '0;
          end else if (cnt_r[k] == CNT_LAST) begin
            state_s[k] = STABLE_HI;
            cnt_s[k]   = '0;
            lvl_s[k]   = 1'b1;
          end else begin
            cnt_s[k] = cnt_r[k] + CNT_W'(1);
          end
        end
        default: begin
          state_s[k] = STABLE_HI;
          cnt_s[k]   = '0;
          lvl_s[k]   = 1'b1;
        end
      endcase
    end
  end

  // FSM state, counter and debounced-level registers
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 2; k++) begin
        state_r[k] <= STABLE_HI;
        cnt_r[k]   <= '0;
      end
      lvl_r <= 2'b11;
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_r[k] <= state_s[k];
        cnt_r[k]   <= cnt_s[k];
      end
      lvl_r <= lvl_s;
    end
  end

  // A press is the edge where the debounced level goes high to low
  assign fall_s = lvl_r & ~lvl_s;

  // Step pulse and press counter; a load press clears before the same-edge step counts
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      step_r      <= 1'b0;
      press_cnt_r <= 10'd0;
    end else begin
      step_r <= fall_s[0];
      if (fall_s[1]) begin
        press_cnt_r <= fall_s[0] ? 10'd1 : 10'd0;
      end else if (fall_s[0]) begin
        press_cnt_r <= press_cnt_r + 10'd1;
      end else begin
        press_cnt_r <= press_cnt_r;
      end
    end
  end

  assign step_o      = step_r;
  assign load_n_o    = lvl_r[1];
  assign press_cnt_o = press_cnt_r;
  assign busy_o      = (state_r[0] == COUNT_LO) || (state_r[0] == COUNT_HI) ||
                       (state_r[1] == COUNT_LO) || (state_r[1] == COUNT_HI);

endmodule

// File: tb/tb_key_conditioner.sv
// Directed self-checking bench for key_conditioner with DEBOUNCE_CYCLES=4
// (an accepted change appears at edge 7 after the key moves).
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] key;
  logic       step;
  logic       load_n;
  logic [9:0] press_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  key_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50   (clk),
    .RST        (rst),
    .KEY        (key),
    .step_o     (step),
    .load_n_o   (load_n),
    .press_cnt_o(press_cnt),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold the step key low then high, returning the number of pulses seen
  task automatic press_step(output int pulses);
    pulses = 0;
    key[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step) pulses++;
    end
    key[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int total;
    int busy_seen;

    rst = 1'b1;
    key = 2'b11;
    #1;
    check_value("rst_step", 32'(step), 32'd0);
    check_value("rst_load_n", 32'(load_n), 32'd1);
    check_value("rst_cnt", 32'(press_cnt), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Idle keys
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (step) pulses++;
      if (busy) busy_seen++;
    end
    check_value("idle_pulses", 32'(pulses), 32'd0);
    check_value("idle_busy", 32'(busy_seen), 32'd0);
    check_value("idle_load_n", 32'(load_n), 32'd1);
    check_value("idle_cnt", 32'(press_cnt), 32'd0);

    // Single clean press: pulse at edge 7, busy on edges 3-6
    key[0] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_value($sformatf("press_step_e%0d", e), 32'(step), (e == 7) ? 32'd1 : 32'd0);
      check_value($sformatf("press_busy_e%0d", e), 32'(busy), (e >= 3 && e <= 6) ? 32'd1 : 32'd0);
    end
    check_value("press_cnt", 32'(press_cnt), 32'd1);
    check_value("press_load_n", 32'(load_n), 32'd1);

    // Release: debounced but no pulse
    key[0] = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (step) pulses++;
      check_value($sformatf("rel_busy_e%0d", e), 32'(busy), (e >= 3 && e <= 6) ? 32'd1 : 32'd0);
    end
    check_value("rel_pulses", 32'(pulses), 32'd0);
    check_value("rel_cnt", 32'(press_cnt), 32'd1);

    // Three-cycle glitch is rejected
    key[0] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (step) pulses++;
    end
    key[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step) pulses++;
    end
    check_value("glitch_pulses", 32'(pulses), 32'd0);
    check_value("glitch_cnt", 32'(press_cnt), 32'd1);
    check_value("glitch_busy", 32'(busy), 32'd0);

    // 1024 presses from a fresh reset wrap the counter to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total = 0;
    for (int p = 0; p < 1024; p++) begin
      press_step(pulses);
      total += pulses;
      if (p == 1022) check_value("wrap_cnt_1023", 32'(press_cnt), 32'd1023);
    end
    check_value("wrap_pulses", 32'(total), 32'd1024);
    check_value("wrap_cnt", 32'(press_cnt), 32'd0);

    // Bring count to 5, then load and step on the same cycle
    for (int p = 0; p < 5; p++) press_step(pulses);
    check_value("pre_load_cnt", 32'(press_cnt), 32'd5);
    key = 2'b00;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) begin
        check_value("both_e6_load_n", 32'(load_n), 32'd1);
        check_value("both_e6_cnt", 32'(press_cnt), 32'd5);
      end
    end
    check_value("both_e7_load_n", 32'(load_n), 32'd0);
    check_value("both_e7_step", 32'(step), 32'd1);
    check_value("both_e7_cnt", 32'(press_cnt), 32'd1);
    tick();
    check_value("both_e8_step", 32'(step), 32'd0);
    key = 2'b11;
    for (int i = 0; i < 12; i++) tick();
    check_value("both_rel_load_n", 32'(load_n), 32'd1);
    check_value("both_rel_cnt", 32'(press_cnt), 32'd1);

    // Reset between edges during COUNT_LO aborts the count
    key[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_value("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_value("abort_step", 32'(step), 32'd0);
    check_value("abort_load_n", 32'(load_n), 32'd1);
    check_value("abort_cnt", 32'(press_cnt), 32'd0);
    check_value("abort_busy", 32'(busy), 32'd0);
    key = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step) pulses++;
    end
    check_value("abort_pulses", 32'(pulses), 32'd0);
    check_value("abort_cnt_after", 32'(press_cnt), 32'd0);

    // Key held low across reset release is debounced as a new press
    rst = 1'b1;
    key[0] = 1'b0;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_value($sformatf("held_step_e%0d", e), 32'(step), (e == 7) ? 32'd1 : 32'd0);
    end
    check_value("held_cnt", 32'(press_cnt), 32'd1);
    key[0] = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
